// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage.
// Provides the default channel geometry, the packed beat payload and the
// control-word field positions that the execute stage decodes.
package id_ex_pkg;

    localparam int unsigned ID_EX_DATA_W = 32;
    localparam int unsigned ID_EX_NUM_CH = 2;
    localparam int unsigned ID_EX_CTRL_W = 8;
    localparam int unsigned ID_EX_CNT_W  = 16;

    // One beat at the default geometry: all operand channels plus control.
    typedef struct packed {
        logic [ID_EX_NUM_CH*ID_EX_DATA_W-1:0] data;
        logic [ID_EX_CTRL_W-1:0]              ctrl;
    } id_ex_beat_t;

    // Control-word fields consumed by execute.
    localparam int unsigned CTRL_ALU_OP_LSB  = 0;
    localparam int unsigned CTRL_ALU_OP_W    = 4;
    localparam int unsigned CTRL_MEM_RD_BIT  = 4;
    localparam int unsigned CTRL_MEM_WR_BIT  = 5;
    localparam int unsigned CTRL_REG_WR_BIT  = 6;
    localparam int unsigned CTRL_USE_IMM_BIT = 7;

    // Width of a flattened beat (operands above control).
    function automatic int unsigned beat_w(input int unsigned num_ch,
                                           input int unsigned data_w,
                                           input int unsigned ctrl_w);
        return num_ch * data_w + ctrl_w;
    endfunction

endpackage

// File: rtl/id_ex_pipe_stage_if.sv
// Decode-side and execute-side handshake bundle of the ID/EX stage.
// Modports:
//   slave  - the pipeline stage (consumes in_*, produces out_*)
//   master - the surrounding pipeline (produces in_*, consumes out_*)
// Signals:
//   in_valid/in_ready/in_data/in_ctrl     decode -> stage beat
//   out_valid/out_ready/out_data/out_ctrl stage -> execute beat
interface id_ex_pipe_stage_if
    import id_ex_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_DATA_W,
    parameter int unsigned NUM_CH = ID_EX_NUM_CH,
    parameter int unsigned CTRL_W = ID_EX_CTRL_W
);

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [CTRL_W-1:0]        in_ctrl;

    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [CTRL_W-1:0]        out_ctrl;

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

endinterface

// File: rtl/id_ex_skid_slot.sv
// Single holding register with a valid bit, used for both the main slot and
// the skid slot of the ID/EX stage.
// Ports:
//   clock, reset_n  rising-edge clock, synchronous active-low reset
//   flush           empty the slot; the data register keeps its value
//   load            capture d and mark valid (wins over unload)
//   unload          mark empty (the held beat has been consumed)
//   d / q           beat in / held beat
//   valid           slot holds a beat
module id_ex_skid_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Valid tracking: flush beats load beats unload.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

    // Data register: a flushed beat never overwrites the held value.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load && !flush) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage: registers NUM_CH operand channels plus a control
// word between decode and execute with a valid/ready handshake, a
// synchronous flush and a saturating stall counter.
// Build option: define ID_EX_SKID_EN for a 2-entry stage with a registered
// in_ready (skid slot empty); otherwise a 1-entry stage whose in_ready is
// out_ready || !out_valid.
// Ports:
//   clock, reset_n  rising-edge clock, synchronous active-low reset
//   bus             handshake bundle (slave modport): in_* from decode,
//                   out_* to execute
//   flush           squash held beats and any beat accepted this cycle
//   stall_count     cycles with out_valid=1 and out_ready=0, saturating
module id_ex_pipe_stage
    import id_ex_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_DATA_W,
    parameter int unsigned NUM_CH = ID_EX_NUM_CH,
    parameter int unsigned CTRL_W = ID_EX_CTRL_W,
    parameter int unsigned CNT_W  = ID_EX_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    id_ex_pipe_stage_if.slave    bus,
    input  logic                 flush,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int unsigned OPS_W  = NUM_CH * DATA_W;
    localparam int unsigned BEAT_W = beat_w(NUM_CH, DATA_W, CTRL_W);

    logic              in_ready_c;
    logic              accept;
    logic              deliver;
    logic              main_valid;
    logic              main_load;
    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] main_d;
    logic [BEAT_W-1:0] main_q;
    logic [CNT_W-1:0]  stall_q;

    // Operands above control so a beat moves as one word.
    assign in_beat = {bus.in_data, bus.in_ctrl};
    assign deliver = main_valid && bus.out_ready;
    assign accept  = bus.in_valid && in_ready_c;

`ifdef ID_EX_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic [BEAT_W-1:0] skid_q;
    logic              main_free;

    // in_ready comes straight from the skid valid flop, never from out_ready.
    assign in_ready_c = !skid_valid;
    assign main_free  = !main_valid || deliver;

    // A full skid refills main on delivery (no accept then, in_ready=0);
    // otherwise an accepted beat goes to main if it frees, else to skid.
    assign main_load  = (skid_valid && deliver) || (accept && main_free);
    assign main_d     = skid_valid ? skid_q : in_beat;
    assign skid_load  = accept && !main_free;

    id_ex_skid_slot #(.W(BEAT_W)) u_skid_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .load    (skid_load),
        .unload  (deliver),
        .d       (in_beat),
        .valid   (skid_valid),
        .q       (skid_q)
    );
`else
    assign in_ready_c = bus.out_ready || !main_valid;
    assign main_load  = accept;
    assign main_d     = in_beat;
`endif

    id_ex_skid_slot #(.W(BEAT_W)) u_main_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .load    (main_load),
        .unload  (deliver),
        .d       (main_d),
        .valid   (main_valid),
        .q       (main_q)
    );

    // Stall counter: only reset clears it, flush leaves it alone.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (main_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_q[BEAT_W-1 -: OPS_W];
    assign bus.out_ctrl  = main_q[CTRL_W-1:0];
    assign stall_count   = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage (CNT_W=4 build so saturation is short).
// Covers reset, streaming, stall with back-pressure, flush, counter
// saturation and reset mid-stall, in both skid and non-skid builds.
module tb_id_ex_pipe_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic             clock;
    logic             reset_n;
    logic             flush;
    logic [CNT_W-1:0] stall_count;

    int checks;
    int errors;

    id_ex_pipe_stage_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W)) bus ();

    id_ex_pipe_stage #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .flush       (flush),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ch0, input logic [31:0] ch1,
                         input logic [7:0] ctrl);
        bus.in_valid = v;
        bus.in_data  = {ch1, ch0};
        bus.in_ctrl  = ctrl;
    endtask

    task automatic check_beat(input string tag, input logic v, input logic [31:0] ch0,
                              input logic [31:0] ch1, input logic [7:0] ctrl);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
        check({tag, ".data"},  64'(bus.out_data),  {ch1, ch0});
        check({tag, ".ctrl"},  64'(bus.out_ctrl),  64'(ctrl));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 8'h0);

        // Reset state
        tick();
        tick();
        check_beat("reset", 1'b0, 32'h0, 32'h0, 8'h00);
        check("reset.stall", 64'(stall_count), 64'd0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);

        // Back-to-back stream, first accept on the first edge out of reset
        reset_n = 1'b1;
        drive(1'b1, 32'h11111111, 32'h22222222, 8'h5A);
        tick();
        check_beat("s1", 1'b1, 32'h11111111, 32'h22222222, 8'h5A);
        drive(1'b1, 32'h33333333, 32'h44444444, 8'hA5);
        tick();
        check_beat("s2", 1'b1, 32'h33333333, 32'h44444444, 8'hA5);
        drive(1'b1, 32'h55555555, 32'h66666666, 8'h3C);
        tick();
        check_beat("s3", 1'b1, 32'h55555555, 32'h66666666, 8'h3C);
        check("s3.stall", 64'(stall_count), 64'd0);

        // Stall five cycles while beat D is offered
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h77777777, 32'h88888888, 8'h0F);
        tick();
`ifdef ID_EX_SKID_EN
        bus.in_valid = 1'b0;   // D went into the skid slot on this edge
`endif
        check("stall.in_ready", 64'(bus.in_ready), 64'd0);
        repeat (4) tick();
        check_beat("stall.hold", 1'b1, 32'h55555555, 32'h66666666, 8'h3C);
        check("stall.count5", 64'(stall_count), 64'd5);

        // Release: main beat already seen, then D, then E, then empty
        bus.out_ready = 1'b1;
        tick();
        check_beat("rel.D", 1'b1, 32'h77777777, 32'h88888888, 8'h0F);
        check("rel.in_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 32'h9999AAAA, 32'hBBBBCCCC, 8'hE1);
        tick();
        check_beat("rel.E", 1'b1, 32'h9999AAAA, 32'hBBBBCCCC, 8'hE1);
        drive(1'b0, 32'h0, 32'h0, 8'h0);
        tick();
        check("rel.empty", 64'(bus.out_valid), 64'd0);
        check("rel.stall", 64'(stall_count), 64'd5);

        // Fill main with F (and skid with G), then flush with H offered
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 8'h12);
        tick();
        check_beat("fill.F", 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 8'h12);
        drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 8'h34);
        tick();
        check("fill.in_ready", 64'(bus.in_ready), 64'd0);
        check("fill.stall", 64'(stall_count), 64'd6);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 32'hCAFEBABE, 8'h56);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 8'h0);
        check_beat("flush", 1'b0, 32'h0F0F0F0F, 32'hF0F0F0F0, 8'h12);
        check("flush.stall", 64'(stall_count), 64'd6);
        check("flush.in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("flush.no_ghost", 64'(bus.out_valid), 64'd0);

        // Load I then stall 2^CNT_W+3 cycles: counter pins at all-ones
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h13579BDF, 32'h2468ACE0, 8'h78);
        tick();
        drive(1'b0, 32'h0, 32'h0, 8'h0);
        check_beat("sat.I", 1'b1, 32'h13579BDF, 32'h2468ACE0, 8'h78);
        check("sat.start", 64'(stall_count), 64'd6);
        repeat (9) tick();
        check("sat.at15", 64'(stall_count), 64'd15);
        repeat ((1 << CNT_W) + 3 - 9) tick();
        check("sat.hold", 64'(stall_count), 64'd15);
        check_beat("sat.stable", 1'b1, 32'h13579BDF, 32'h2468ACE0, 8'h78);

        // Reset mid-stall with a beat and flush-free handshake pending
        reset_n = 1'b0;
        drive(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 8'h9C);
        tick();
        check_beat("rst2", 1'b0, 32'h0, 32'h0, 8'h00);
        check("rst2.stall", 64'(stall_count), 64'd0);
        check("rst2.in_ready", 64'(bus.in_ready), 64'd1);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, 32'h0, 8'h0);
        check_beat("rst2.J", 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 8'h9C);
        tick();
        check("rst2.drain", 64'(bus.out_valid), 64'd0);
        check("rst2.stall_end", 64'(stall_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_stage.md
# id_ex_pipe_stage

Parametrised ID/EX pipeline stage register carrying NUM_CH operand channels and a control word from decode to execute. Adds a valid/ready handshake, synchronous flush, optional skid buffering, and a saturating stall counter. Replaces the per-operand fixed 32-bit ID/EX latches with one stage that supports back-pressure and hazard squashing.

## Interface
Parameters:
- DATA_W, 32, width of one operand channel
- NUM_CH, 2, number of operand channels (e.g. A, B)
- CTRL_W, 8, width of the decoded control word
- CNT_W, 16, width of the stall counter

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  decode offers a beat
- in_ready  out  1  stage can accept a beat
- in_data  in  NUM_CH*DATA_W  operands; channel k at [k*DATA_W +: DATA_W]
- in_ctrl  in  CTRL_W  control word
- flush  in  1  squash all held and incoming beats
- out_valid  out  1  execute-side beat valid
- out_ready  in  1  execute accepts the beat
- out_data  out  NUM_CH*DATA_W  registered operands
- out_ctrl  out  CTRL_W  registered control word
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Accept when in_valid && in_ready; deliver when out_valid && out_ready.
- Main slot drives out_*. Main slot loads the accepted beat when empty or being delivered this cycle.
- Data and control for a beat always move together; no channel-level partial updates.
- flush (priority over everything except reset): next edge out_valid=0, skid slot emptied, any beat accepted in the flush cycle discarded. Data registers hold their values.
- stall_count: +1 each cycle with out_valid && !out_ready; saturates at all-ones; cleared only by reset; unaffected by flush.
- Reset: out_valid=0, out_data=0, out_ctrl=0, skid empty, stall_count=0, in_ready=1.
- Ordering: beats leave in acceptance order; none dropped or duplicated except by flush.

## Timing
- Latency: accept on edge N -> out_valid=1 from edge N.
- Throughput: 1 beat/cycle under continuous out_ready=1.
- Simultaneous accept and deliver with main slot full: new beat replaces it on the same edge, with no bubble.
- Reset asserted mid-stream overrides flush and handshakes. First accept is possible on the first edge with reset_n=1.

## Configuration
- ID_EX_SKID_EN defined: 2-entry stage. in_ready is registered (= skid slot empty) with no combinational path from out_ready. When a beat is accepted while main is full and not delivered, it goes to the skid slot and in_ready drops next cycle. On the next delivery, skid moves to main and in_ready rises.
- Undefined: 1-entry stage. in_ready = out_ready || !out_valid (combinational). No skid storage.

## Structure
- Shared package id_ex_pkg: DATA_W/NUM_CH/CTRL_W defaults, typedef for the beat struct (data + ctrl), and the control-word field constants used by execute.
- One natural sub-module, id_ex_skid_slot: single holding register with valid bit. It is instantiated for the main slot, and for the skid slot under ID_EX_SKID_EN.

## Test plan
- Reset then stream 0x11111111/0x22222222, ctrl 0x5A with out_ready=1 -> same values on out_* next cycle. Back-to-back beats arrive with no bubbles. stall_count=0.
- Hold out_ready=0 with out_valid=1 for 5 cycles -> out_* stable, stall_count=5. With ID_EX_SKID_EN, one extra beat is absorbed and then in_ready=0.
- Release out_ready after the skid fill -> beats exit in order: main beat, then skid beat, then the next input. in_ready returns to 1.
- Assert flush with main and skid full and in_valid=1 -> next cycle out_valid=0, all three beats gone, stall_count unchanged.
- Force a stall for 2^CNT_W+3 cycles (CNT_W=4 build) -> stall_count holds at 0xF.
- Assert reset_n=0 mid-stall -> next edge all outputs zero, in_ready=1. First accepted beat after release appears intact.
